// File: rtl/adder_pkg.sv
// Shared types and defaults for the pipelined add/subtract unit.
// Carry chain is cut into STAGES equal segments of segWidth() bits.
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 2;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } opT;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } flagsT;

  function automatic int segWidth(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The adder uses the slave view; the producer/consumer side uses master.
interface pipelined_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero
  );

endinterface

// File: rtl/adder_segment.sv
// One registered SEG-bit slice of the carry chain: adds its operand slice plus the
// incoming carry and also folds the running "all result bits zero so far" flag.
module adder_segment #(
  parameter int SEG = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  input  logic           en_i,
  input  logic           valid_i,
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           carry_i,
  input  logic           zero_i,
  output logic           valid_o,
  output logic [SEG-1:0] sum_o,
  output logic           carry_o,
  output logic           zero_o
);

  logic [SEG:0]   total_d;
  logic           valid_q;
  logic [SEG-1:0] sum_q;
  logic           carry_q;
  logic           zero_q;

  assign total_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, carry_i};

  // Flush only kills the valid bit; data is don't-care once invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (en_i) begin
        valid_q <= valid_i;
      end
      if (en_i) begin
        sum_q   <= total_d[SEG-1:0];
        carry_q <= total_d[SEG];
        zero_q  <= zero_i && (total_d[SEG-1:0] == '0);
      end
    end
  end

  assign valid_o = valid_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract with valid/ready handshake and flush.
// Stage k resolves bits [k*SEG +: SEG]; operands and finished low bits ride alongside.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipelined_adder_if.slave bus
);

  localparam int SEG  = segWidth(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  opT               op;
  logic             advance;
  flagsT            flags;

  logic [WIDTH-1:0] aSkew_d   [STAGES];
  logic [WIDTH-1:0] bxSkew_d  [STAGES];
  logic [WIDTH-1:0] resLow_d  [STAGES];
  logic [WIDTH-1:0] aSkew_q   [STAGES];
  logic [WIDTH-1:0] bxSkew_q  [STAGES];
  logic [WIDTH-1:0] resLow_q  [STAGES];
  logic [WIDTH-1:0] resDone   [STAGES];

  logic             carryIn   [STAGES];
  logic             zeroIn    [STAGES];
  logic             validIn   [STAGES];
  logic             carryOut  [STAGES];
  logic             zeroOut   [STAGES];
  logic             validOut  [STAGES];
  logic [SEG-1:0]   segSum    [STAGES];

  assign op      = opT'(bus.sub);
  assign advance = !validOut[LAST] || bus.out_ready;

  // Stage 0 takes the bus directly; later stages take the previous stage's registers.
  always_comb begin
    aSkew_d[0]  = bus.a;
    bxSkew_d[0] = (op == SUB) ? ~bus.b : bus.b;
    resLow_d[0] = '0;
    carryIn[0]  = (op == SUB);
    zeroIn[0]   = 1'b1;
    validIn[0]  = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      aSkew_d[k]  = aSkew_q[k-1];
      bxSkew_d[k] = bxSkew_q[k-1];
      resLow_d[k] = resDone[k-1];
      carryIn[k]  = carryOut[k-1];
      zeroIn[k]   = zeroOut[k-1];
      validIn[k]  = validOut[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      resDone[k]               = resLow_q[k];
      resDone[k][k*SEG +: SEG] = segSum[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        aSkew_q[k]  <= '0;
        bxSkew_q[k] <= '0;
        resLow_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        aSkew_q[k]  <= aSkew_d[k];
        bxSkew_q[k] <= bxSkew_d[k];
        resLow_q[k] <= resLow_d[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    adder_segment #(
      .SEG (SEG)
    ) uSegment (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .en_i    (advance),
      .valid_i (validIn[k]),
      .a_i     (aSkew_d[k][k*SEG +: SEG]),
      .b_i     (bxSkew_d[k][k*SEG +: SEG]),
      .carry_i (carryIn[k]),
      .zero_i  (zeroIn[k]),
      .valid_o (validOut[k]),
      .sum_o   (segSum[k]),
      .carry_o (carryOut[k]),
      .zero_o  (zeroOut[k])
    );
  end

  // Overflow uses the operand MSBs that travelled with the beat, so it stays 0 after reset.
  always_comb begin
    flags.carry    = carryOut[LAST];
    flags.zero     = zeroOut[LAST];
    flags.overflow = (aSkew_q[LAST][WIDTH-1] == bxSkew_q[LAST][WIDTH-1]) &&
                     (resDone[LAST][WIDTH-1] != aSkew_q[LAST][WIDTH-1]);
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = validOut[LAST];
  assign bus.sum       = resDone[LAST];
  assign bus.carry     = flags.carry;
  assign bus.overflow  = flags.overflow;
  assign bus.zero      = flags.zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: four configurations share clock, reset and flush;
// the WIDTH=32/STAGES=2 instance also covers streaming, back-pressure, flush and reset.
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
  } vecT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) bus1 ();
  pipelined_adder_if #(.WIDTH(32)) bus2 ();
  pipelined_adder_if #(.WIDTH(32)) bus4 ();
  pipelined_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));
  pipelined_adder #(.WIDTH(32), .STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2));
  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus4));
  pipelined_adder #(.WIDTH(8),  .STAGES(4)) dut8 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus8));

  vecT         v32 [6];
  vecT         v8  [6];
  logic [31:0] sa  [8];
  logic [31:0] sb  [8];
  logic [31:0] ss  [8];
  logic        rdyPat [4];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  task automatic checkStage(input string tag, input int cyc, input int lat, input logic v,
                            input logic [31:0] s, input logic c, input logic o, input logic z,
                            input vecT e);
    if (cyc < lat) begin
      checkOutput({tag, "_early_valid"}, 32'(v), 32'd0);
    end else if (cyc == lat) begin
      checkOutput({tag, "_valid"}, 32'(v), 32'd1);
      checkOutput({tag, "_sum"},   s, e.sum);
      checkOutput({tag, "_carry"}, 32'(c), 32'(e.carry));
      checkOutput({tag, "_ovf"},   32'(o), 32'(e.ovf));
      checkOutput({tag, "_zero"},  32'(z), 32'(e.zero));
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic valid);
    bus2.a        = a;
    bus2.b        = b;
    bus2.sub      = sub;
    bus2.in_valid = valid;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int got;
    logic mv0;
    logic mv1;
    logic outRdy;

    v32[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    v32[1] = '{32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    v32[2] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    v32[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    v32[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    v32[5] = '{32'h00000001, 32'h00000002, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    v8[0]  = '{32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0};
    v8[1]  = '{32'h5A, 32'h5A, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1};
    v8[2]  = '{32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1, 1'b0};
    v8[3]  = '{32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0};
    v8[4]  = '{32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1};
    v8[5]  = '{32'h01, 32'h02, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0};
    sa = '{32'h00000001, 32'h0000FFFF, 32'h11111111, 32'hFFFFFFFF,
           32'h80000000, 32'h12345678, 32'h0F0F0F0F, 32'h00008000};
    sb = '{32'h00000002, 32'h00000001, 32'h22222222, 32'h00000002,
           32'h80000000, 32'h11111111, 32'hF0F0F0F0, 32'h00008000};
    ss = '{32'h00000003, 32'h00010000, 32'h33333333, 32'h00000001,
           32'h00000000, 32'h23456789, 32'hFFFFFFFF, 32'h00010000};
    rdyPat = '{1'b1, 1'b0, 1'b0, 1'b1};

    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.sub = 1'b0; bus2.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sub = 1'b0; bus8.out_ready = 1'b1;

    #3;
    checkOutput("reset_valid",    32'(bus2.out_valid), 32'd0);
    checkOutput("reset_ready",    32'(bus2.in_ready),  32'd1);
    checkOutput("reset_sum",      bus2.sum,            32'd0);
    checkOutput("reset_zero",     32'(bus2.zero),      32'd0);
    checkOutput("reset_w8_valid", 32'(bus8.out_valid), 32'd0);
    checkOutput("reset_w8_ready", 32'(bus8.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus1.a = v32[i].a; bus1.b = v32[i].b; bus1.sub = v32[i].sub; bus1.in_valid = 1'b1;
      bus2.a = v32[i].a; bus2.b = v32[i].b; bus2.sub = v32[i].sub; bus2.in_valid = 1'b1;
      bus4.a = v32[i].a; bus4.b = v32[i].b; bus4.sub = v32[i].sub; bus4.in_valid = 1'b1;
      bus8.a = v8[i].a[7:0]; bus8.b = v8[i].b[7:0]; bus8.sub = v8[i].sub; bus8.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.in_valid = 1'b0; bus2.in_valid = 1'b0; bus4.in_valid = 1'b0; bus8.in_valid = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
        checkStage("s1", cyc, 1, bus1.out_valid, bus1.sum, bus1.carry, bus1.overflow, bus1.zero, v32[i]);
        checkStage("s2", cyc, 2, bus2.out_valid, bus2.sum, bus2.carry, bus2.overflow, bus2.zero, v32[i]);
        checkStage("s4", cyc, 4, bus4.out_valid, bus4.sum, bus4.carry, bus4.overflow, bus4.zero, v32[i]);
        checkStage("w8", cyc, 4, bus8.out_valid, {24'd0, bus8.sum}, bus8.carry, bus8.overflow, bus8.zero, v8[i]);
        @(negedge clk);
      end
    end

    // Streaming: mv0/mv1 model stage occupancy, results must come out in issue order.
    sent = 0; got = 0; mv0 = 1'b0; mv1 = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      outRdy         = rdyPat[cyc % 4];
      bus2.out_ready = outRdy;
      if (sent < 8) applyStimulus(sa[sent], sb[sent], 1'b0, 1'b1);
      else          applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
      #1;
      checkOutput("stream_valid", 32'(bus2.out_valid), 32'(mv1));
      checkOutput("stream_ready", 32'(bus2.in_ready),  32'(!mv1 || outRdy));
      if (bus2.out_valid && outRdy) begin
        checkOutput("stream_sum", bus2.sum, ss[got]);
        got++;
      end
      if (!mv1 || outRdy) begin
        mv1 = mv0;
        mv0 = (sent < 8);
        if (sent < 8) sent++;
      end
    end
    checkOutput("stream_count", 32'(got), 32'd8);
    @(negedge clk);
    bus2.out_ready = 1'b1;
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);

    // Flush with one beat in stage 0 and a second beat offered alongside the flush.
    applyStimulus(32'd10, 32'd20, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(32'd5, 32'd6, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("flush_ready", 32'(bus2.in_ready), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      checkOutput("flush_idle", 32'(bus2.out_valid), 32'd0);
      @(negedge clk);
    end
    applyStimulus(32'h00FFFFFF, 32'd1, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("flush_next_early", 32'(bus2.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("flush_next_valid", 32'(bus2.out_valid), 32'd1);
    checkOutput("flush_next_sum",   bus2.sum,            32'h01000000);

    // Flush while the output is being consumed and another beat sits in stage 0.
    @(negedge clk);
    applyStimulus(32'd7, 32'd8, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(32'd1, 32'd1, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("flush_consume_valid", 32'(bus2.out_valid), 32'd1);
    checkOutput("flush_consume_sum",   bus2.sum,            32'd15);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_consume_after", 32'(bus2.out_valid), 32'd0);
    @(negedge clk);
    checkOutput("flush_consume_drop",  32'(bus2.out_valid), 32'd0);

    // Asynchronous reset between edges with two beats in flight.
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(32'h7FFFFFFF, 32'd1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("prereset_sum",   bus2.sum,          32'hFFFFFFFE);
    checkOutput("prereset_carry", 32'(bus2.carry),   32'd1);
    #1;
    rst_n = 1'b0;
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checkOutput("midreset_valid", 32'(bus2.out_valid), 32'd0);
    checkOutput("midreset_sum",   bus2.sum,            32'd0);
    checkOutput("midreset_carry", 32'(bus2.carry),     32'd0);
    checkOutput("midreset_ovf",   32'(bus2.overflow),  32'd0);
    checkOutput("midreset_zero",  32'(bus2.zero),      32'd0);
    checkOutput("midreset_ready", 32'(bus2.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("postreset_valid", 32'(bus2.out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
